// File: rtl/display_pkg.sv
// Shared constants, FSM state and sample bundle
// for the 7-segment display readback block.
package display_pkg;

  localparam int SEG_W  = 7;
  localparam int DIGITS = 4;
  localparam int BCD_W  = 4;

  localparam logic [SEG_W-1:0] SEG_0     = 7'b1111110;
  localparam logic [SEG_W-1:0] SEG_1     = 7'b0110000;
  localparam logic [SEG_W-1:0] SEG_2     = 7'b1101101;
  localparam logic [SEG_W-1:0] SEG_3     = 7'b1111001;
  localparam logic [SEG_W-1:0] SEG_4     = 7'b0110011;
  localparam logic [SEG_W-1:0] SEG_5     = 7'b1011011;
  localparam logic [SEG_W-1:0] SEG_6     = 7'b1011111;
  localparam logic [SEG_W-1:0] SEG_7     = 7'b1110000;
  localparam logic [SEG_W-1:0] SEG_8     = 7'b1111111;
  localparam logic [SEG_W-1:0] SEG_9     = 7'b1111011;
  localparam logic [SEG_W-1:0] SEG_BLANK = 7'b0000000;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_TRACK = 2'd1,
    ST_HOLD  = 2'd2
  } state_t;

  typedef struct packed {
    logic [SEG_W-1:0]  seg;
    logic [DIGITS-1:0] an;
  } sample_t;

  typedef logic [DIGITS-1:0][BCD_W-1:0] digits_t;

  function automatic logic is_onehot(
    input logic [DIGITS-1:0] v
  );
    return (v != '0) &&
           ((v & (v - DIGITS'(1))) == '0);
  endfunction

  // Caller masks to zero unless one-hot.
  function automatic logic [1:0] slot_of(
    input logic [DIGITS-1:0] oh
  );
    logic [1:0] s;
    s = 2'd0;
    unique case (1'b1)
      oh[0]:   s = 2'd0;
      oh[1]:   s = 2'd1;
      oh[2]:   s = 2'd2;
      oh[3]:   s = 2'd3;
      default: s = 2'd0;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/seg_glyph_lookup.sv
// Combinational 7-segment glyph decoder:
// pattern -> BCD digit, blank flag, validity.
module seg_glyph_lookup
  import display_pkg::*;
(
  input  logic [SEG_W-1:0] pat,
  output logic             valid,
  output logic             is_blank,
  output logic [BCD_W-1:0] digit
);

  always_comb begin
    valid    = 1'b1;
    is_blank = 1'b0;
    digit    = '0;
    unique case (pat)
      SEG_0:     digit = 4'd0;
      SEG_1:     digit = 4'd1;
      SEG_2:     digit = 4'd2;
      SEG_3:     digit = 4'd3;
      SEG_4:     digit = 4'd4;
      SEG_5:     digit = 4'd5;
      SEG_6:     digit = 4'd6;
      SEG_7:     digit = 4'd7;
      SEG_8:     digit = 4'd8;
      SEG_9:     digit = 4'd9;
      SEG_BLANK: is_blank = 1'b1;
      default:   valid = 1'b0;
    endcase
  end

endmodule

// File: rtl/display_readback.sv
// Recovers BCD digits from a multiplexed 7-segment
// drive; publishes complete 4-digit frames only.
module display_readback
  import display_pkg::*;
#(
  parameter int STABLE_CYCLES = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [SEG_W-1:0]        seg,
  input  logic [DIGITS-1:0]       an,
  input  logic                    err_clr,
  output logic [DIGITS*BCD_W-1:0] bcd,
  output logic [DIGITS-1:0]       blank,
  output logic                    frame_valid,
  output logic                    err
);

  localparam int CNT_W = 4;
  localparam logic [CNT_W-1:0] CNT_MAX =
    CNT_W'(STABLE_CYCLES - 1);

  sample_t           cur_q;
  sample_t           prv_q;
  logic              changed;
  logic [CNT_W-1:0]  cnt_q;
  logic [CNT_W-1:0]  cnt_d;
  state_t            st_q;
  state_t            st_d;
  logic              try_cap;

  logic              g_valid;
  logic              g_blank;
  logic [BCD_W-1:0]  g_digit;
  logic              an_ok;
  logic [1:0]        slot;
  logic              cap;
  logic              err_set;
  logic              done;

  digits_t           dig_q;
  digits_t           dig_n;
  logic [DIGITS-1:0] blk_q;
  logic [DIGITS-1:0] blk_n;
  logic [DIGITS-1:0] mask_q;
  logic [DIGITS-1:0] mask_n;
  digits_t           bcd_q;
  logic [DIGITS-1:0] blank_q;
  logic              fv_q;
  logic              err_q;

  // Sample stage plus one-deep history for change detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur_q <= '0;
      prv_q <= '0;
    end else begin
      cur_q <= {seg, an};
      prv_q <= cur_q;
    end
  end

  assign changed = (cur_q != prv_q);

  // cnt_d is the dwell of the current sample,
  // so the capture decision sees it this cycle.
  always_comb begin
    cnt_d = '0;
    if (!changed) begin
      if (cnt_q == CNT_MAX) cnt_d = CNT_MAX;
      else                  cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) st_q <= ST_IDLE;
    else        st_q <= st_d;
  end

  always_comb begin
    st_d = st_q;
    if (changed) begin
      st_d = (cur_q.an == '0) ? ST_IDLE : ST_TRACK;
    end else begin
      unique case (st_q)
        ST_TRACK: if (cnt_d == CNT_MAX) st_d = ST_HOLD;
        default:  st_d = st_q;
      endcase
    end
  end

  always_comb begin
    try_cap = (st_q == ST_TRACK) && !changed &&
              (cnt_d == CNT_MAX);
  end

  seg_glyph_lookup u_glyph (
    .pat      (cur_q.seg),
    .valid    (g_valid),
    .is_blank (g_blank),
    .digit    (g_digit)
  );

  assign an_ok   = is_onehot(cur_q.an);
  assign slot    = slot_of(an_ok ? cur_q.an : '0);
  assign cap     = try_cap && an_ok && g_valid;
  assign err_set = try_cap && !(an_ok && g_valid);

  always_comb begin
    dig_n  = dig_q;
    blk_n  = blk_q;
    mask_n = mask_q;
    if (cap) begin
      dig_n[slot] = g_digit;
      blk_n[slot] = g_blank;
      mask_n      = mask_q | cur_q.an;
    end
  end

  assign done = cap && (mask_n == '1);

  // Frame outputs take the shadow including the slot written now.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dig_q   <= '0;
      blk_q   <= '0;
      mask_q  <= '0;
      bcd_q   <= '0;
      blank_q <= '1;
      fv_q    <= 1'b0;
    end else begin
      dig_q  <= dig_n;
      blk_q  <= blk_n;
      mask_q <= done ? '0 : mask_n;
      fv_q   <= done;
      if (done) begin
        bcd_q   <= dig_n;
        blank_q <= blk_n;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       err_q <= 1'b0;
    else if (err_set) err_q <= 1'b1;
    else if (err_clr) err_q <= 1'b0;
  end

  assign bcd         = bcd_q;
  assign blank       = blank_q;
  assign frame_valid = fv_q;
  assign err         = err_q;

endmodule

// File: tb/tb_display_readback.sv
// Scoreboard bench for display_readback: directed
// scenarios plus randomized dwells vs a dwell-level model.
module tb_display_readback;

  localparam int STABLE = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [6:0]  seg;
  logic [3:0]  an;
  logic        err_clr;
  logic [15:0] bcd;
  logic [3:0]  blank;
  logic        frame_valid;
  logic        err;

  display_readback #(.STABLE_CYCLES(STABLE)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .seg         (seg),
    .an          (an),
    .err_clr     (err_clr),
    .bcd         (bcd),
    .blank       (blank),
    .frame_valid (frame_valid),
    .err         (err)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int frames_seen = 0;
  int frames_pushed = 0;

  logic [19:0] exp_q[$];
  logic [19:0] exp_v;
  logic [19:0] prev_out;

  logic [6:0] gly [10] = '{
    7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
    7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
    7'b1111111, 7'b1111011};

  logic [3:0] m_mask;
  logic [3:0] m_dig [4];
  logic [3:0] m_blk;
  bit         m_err;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s got=%0h want=%0h", nm, act, exp);
    end
  endtask

  function automatic void lookup(input logic [6:0] s,
                                 output bit ok,
                                 output bit blk,
                                 output logic [3:0] d);
    ok = 0; blk = 0; d = 4'd0;
    if (s == 7'd0) begin ok = 1; blk = 1; end
    for (int i = 0; i < 10; i++)
      if (gly[i] == s) begin ok = 1; d = 4'(i); end
  endfunction

  function automatic logic [6:0] rand_bad();
    logic [6:0] s;
    bit ok, b;
    logic [3:0] d;
    for (int i = 0; i < 1000; i++) begin
      s = 7'($urandom);
      lookup(s, ok, b, d);
      if (!ok) return s;
    end
    return 7'b0000001;
  endfunction

  task automatic model_reset();
    m_mask = 4'd0;
    m_blk  = 4'd0;
    m_err  = 0;
    for (int i = 0; i < 4; i++) m_dig[i] = 4'd0;
  endtask

  // A dwell of len cycles captures once if long enough.
  task automatic model_dwell(input logic [6:0] s,
                             input logic [3:0] a,
                             input int len);
    bit ok, b;
    logic [3:0] d;
    if (a == 4'd0 || len < STABLE) return;
    lookup(s, ok, b, d);
    if ($countones(a) != 1 || !ok) begin
      m_err = 1;
      return;
    end
    for (int i = 0; i < 4; i++) if (a[i]) begin
      m_dig[i] = d;
      m_blk[i] = b;
      m_mask[i] = 1'b1;
    end
    if (m_mask == 4'hF) begin
      exp_q.push_back({m_dig[3], m_dig[2], m_dig[1],
                       m_dig[0], m_blk});
      frames_pushed++;
      m_mask = 4'd0;
    end
  endtask

  task automatic dwell(input logic [6:0] s,
                       input logic [3:0] a,
                       input int len);
    model_dwell(s, a, len);
    seg = s;
    an  = a;
    repeat (len) @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_out = {bcd, blank};
    end else begin
      if (frame_valid) begin
        frames_seen++;
        if (exp_q.size() == 0) begin
          chk("frame_unexpected", 32'({bcd, blank}), 32'hFFFFFFFF);
        end else begin
          exp_v = exp_q.pop_front();
          chk("frame", 32'({bcd, blank}), 32'(exp_v));
        end
      end else begin
        chk("no_partial", 32'({bcd, blank}), 32'(prev_out));
      end
      prev_out = {bcd, blank};
    end
  end

  initial begin
    logic [6:0] s, ps;
    logic [3:0] a, pa;
    int fs;

    model_reset();
    seg = 7'd0; an = 4'd0; err_clr = 1'b0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #2;
    chk("rst_bcd", 32'(bcd), 32'h0);
    chk("rst_blank", 32'(blank), 32'hF);
    chk("rst_fv", 32'(frame_valid), 32'h0);
    chk("rst_err", 32'(err), 32'h0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // scan: digit0=4 .. digit3=1
    dwell(gly[4], 4'b0001, 8);
    dwell(gly[3], 4'b0010, 8);
    dwell(gly[2], 4'b0100, 8);
    model_dwell(gly[1], 4'b1000, 8);
    seg = gly[1]; an = 4'b1000;
    repeat (4) @(posedge clk);
    #1 chk("lat_fv_pre", 32'(frame_valid), 32'h0);
    @(posedge clk);
    #1 chk("lat_fv", 32'(frame_valid), 32'h1);
    chk("scan_bcd", 32'(bcd), 32'h1234);
    chk("scan_blank", 32'(blank), 32'h0);
    @(posedge clk);
    #1 chk("fv_one_cycle", 32'(frame_valid), 32'h0);
    repeat (2) @(posedge clk);
    #1 chk("scan_err", 32'(err), 32'h0);

    // blank digit2
    dwell(gly[9], 4'b0001, 8);
    dwell(gly[0], 4'b0010, 8);
    dwell(7'd0,   4'b0100, 8);
    dwell(gly[7], 4'b1000, 8);
    dwell(7'd0, 4'd0, 3);
    chk("blank_bcd", 32'(bcd), 32'h7009);
    chk("blank_flags", 32'(blank), 32'b0100);

    // glitch of 2 cycles between dwells
    dwell(gly[5], 4'b0001, 8);
    dwell(gly[8], 4'b0001, 2);
    dwell(gly[6], 4'b0010, 8);
    dwell(gly[7], 4'b0100, 8);
    dwell(gly[8], 4'b1000, 8);
    dwell(7'd0, 4'd0, 3);
    chk("glitch_bcd", 32'(bcd), 32'h8765);
    chk("glitch_err", 32'(err), 32'h0);

    // invalid seg: flagged once, no mask bit
    dwell(gly[3], 4'b0010, 8);
    model_dwell(7'b0000001, 4'b0001, 12);
    seg = 7'b0000001; an = 4'b0001;
    repeat (4) @(posedge clk);
    #1 chk("err_pre", 32'(err), 32'h0);
    @(posedge clk);
    #1 chk("err_set", 32'(err), 32'h1);
    err_clr = 1'b1;
    @(posedge clk);
    #1 err_clr = 1'b0;
    chk("err_clr", 32'(err), 32'h0);
    repeat (6) @(posedge clk);
    #1 chk("err_once", 32'(err), 32'h0);
    dwell(gly[4], 4'b0100, 8);
    dwell(gly[5], 4'b1000, 8);
    dwell(gly[6], 4'b0001, 8);
    dwell(7'd0, 4'd0, 3);
    chk("err_mask_bcd", 32'(bcd), 32'h5436);

    // multi-hot an, err_clr colliding with new error
    model_dwell(gly[5], 4'b0011, 8);
    seg = gly[5]; an = 4'b0011;
    repeat (4) @(posedge clk);
    #1 chk("multi_pre", 32'(err), 32'h0);
    err_clr = 1'b1;
    @(posedge clk);
    #1 err_clr = 1'b0;
    chk("multi_collide", 32'(err), 32'h1);
    repeat (3) @(posedge clk);
    #1 chk("multi_hold", 32'(err), 32'h1);

    // reset mid-frame
    dwell(gly[1], 4'b0001, 8);
    dwell(gly[2], 4'b0010, 8);
    dwell(gly[3], 4'b0100, 8);
    rst_n = 1'b0;
    #2;
    chk("mid_rst_bcd", 32'(bcd), 32'h0);
    chk("mid_rst_blank", 32'(blank), 32'hF);
    chk("mid_rst_fv", 32'(frame_valid), 32'h0);
    chk("mid_rst_err", 32'(err), 32'h0);
    model_reset();
    seg = 7'd0; an = 4'd0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    fs = frames_seen;
    dwell(gly[9], 4'b1000, 8);
    dwell(7'd0, 4'd0, 4);
    chk("rst_no_frame", 32'(frames_seen), 32'(fs));
    dwell(gly[4], 4'b0001, 8);
    dwell(gly[5], 4'b0010, 8);
    dwell(gly[6], 4'b0100, 8);
    dwell(7'd0, 4'd0, 3);
    chk("rst_frame", 32'(frames_seen), 32'(fs + 1));
    chk("rst_bcd_new", 32'(bcd), 32'h9654);

    // randomized rounds
    ps = 7'd0; pa = 4'd0;
    for (int r = 0; r < 30; r++) begin
      m_err = 0;
      for (int k = 0; k < 6; k++) begin
        int c, q, len;
        do begin
          c = $urandom_range(0, 9);
          if (c < 7)       a = 4'(1 << $urandom_range(0, 3));
          else if (c == 7) a = 4'd0;
          else begin
            do a = 4'($urandom); while ($countones(a) < 2);
          end
          q = $urandom_range(0, 9);
          if (q < 6)       s = gly[$urandom_range(0, 9)];
          else if (q == 6) s = 7'd0;
          else             s = rand_bad();
        end while ({s, a} == {ps, pa});
        len = $urandom_range(1, 9);
        dwell(s, a, len);
        ps = s; pa = a;
      end
      dwell(7'd0, 4'd0, STABLE + 3);
      chk("rand_err", 32'(err), 32'(m_err));
      err_clr = 1'b1;
      @(posedge clk);
      #1 err_clr = 1'b0;
      chk("rand_err_clr", 32'(err), 32'h0);
      ps = 7'd0; pa = 4'd0;
    end

    dwell(7'd0, 4'd0, 10);
    chk("queue_empty", 32'(exp_q.size()), 32'h0);
    chk("frame_count", 32'(frames_seen), 32'(frames_pushed));
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/display_readback.md
DISPLAY_READBACK -- requirements
Module: display_readback

Interface
REQ-001 Parameter STABLE_CYCLES, default 4: consecutive identical samples required before a digit is captured; legal range 2..15.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 seg  input  7  active-high segment pattern, bit6=a through bit0=g.
REQ-005 an  input  4  active-high one-hot digit select; an[0]=rightmost digit.
REQ-006 err_clr  input  1  synchronous clear of err.
REQ-007 bcd  output  16  captured digits; bcd[3:0]=digit0 through bcd[15:12]=digit3.
REQ-008 blank  output  4  per-digit flag; 1 = digit captured as all-off.
REQ-009 frame_valid  output  1  one-cycle pulse when bcd/blank update.
REQ-010 err  output  1  sticky error flag.

Function
REQ-011 Glyph table, one to one: 0=1111110, 1=0110000, 2=1101101, 3=1111001, 4=0110011, 5=1011011, 6=1011111, 7=1110000, 8=1111111, 9=1111011, blank=0000000; any other pattern is invalid.
REQ-012 seg and an are registered once (the sample stage) before any comparison or decode.
REQ-013 Dwell counter: reset to 0 when the current sample differs from the previous sample in any of the 11 bits, else increment, saturating at STABLE_CYCLES-1.
REQ-014 FSM states:
- IDLE: an sample == 0.
- TRACK: counting dwell.
- HOLD: current dwell already captured.
REQ-015 Transitions:
- Any sample change -> TRACK, or -> IDLE if the new an sample is 0.
- TRACK -> HOLD on the capture cycle.
- HOLD stays in HOLD until a sample change.
REQ-016 Capture cycle: in TRACK with the counter at STABLE_CYCLES-1, an one-hot, seg valid; write the decoded digit and blank flag into shadow slot for an, set its mask bit.
REQ-017 Latency: a stable input is captured at the end of cycle 1+STABLE_CYCLES after it first appears at the ports.
REQ-018 Re-capture of a slot already in the mask overwrites the shadow; latest wins.
REQ-019 On the capture edge that completes mask=4'hF, bcd and blank load the full shadow on that same edge, including the slot just captured; frame_valid is high for exactly the following cycle; mask clears to 0.
REQ-020 bcd and blank change only on frame completion; partial frames are never visible.
REQ-021 Blank digit: the shadow nibble is 4'h0 and the blank bit is 1.
REQ-022 Invalid seg at a would-be capture cycle:
- err set; no capture; mask unchanged.
- FSM -> HOLD, so err is flagged once per dwell.
REQ-023 an with more than one bit set at a would-be capture cycle: same handling as REQ-022.
REQ-024 an == 0 is idle and never an error.
REQ-025 err_clr clears err on the next edge; a new error in the same cycle wins (err stays 1).

Reset
REQ-026 While rst_n is low, asynchronously force:
- bcd=16'h0000, blank=4'hF, frame_valid=0, err=0;
- mask=0, shadow=0, counter=0, FSM=IDLE, sample registers=0.
REQ-027 Reset mid-frame discards the partial frame; after release, the first frame_valid requires four fresh captures.

Structure
REQ-028 Shared package display_pkg holds:
- glyph constants SEG_0..SEG_9 and SEG_BLANK;
- SEG_W=7, DIGITS=4, BCD_W=4;
- the FSM state enumeration.
REQ-029 One sub-module seg_glyph_lookup: combinational; input 7-bit pattern; outputs valid, is_blank, 4-bit digit; no other sub-modules.

Verification
REQ-030 Scan 1,2,3,4 on an=0001,0010,0100,1000 (digit0 shows 4, digit3 shows 1), 8 cycles each -> after the 4th capture: bcd=16'h1234, blank=0, one frame_valid pulse, err=0.
REQ-031 Glitch: seg=1111111 held 2 cycles between dwells, STABLE_CYCLES=4 -> no capture, mask unchanged, no err.
REQ-032 seg=0000001 held 8 cycles with an=0001 -> err=1 exactly once, mask unchanged; err_clr pulse -> err=0 next cycle.
REQ-033 an=0011 with seg=SEG_5 held 8 cycles -> err=1, no capture; err_clr asserted in the same cycle as a new error -> err stays 1.
REQ-034 Digit2 blank, others 7,0,9 (digit0=9, digit1=0, digit3=7) -> bcd=16'h7009, blank=4'b0100.
REQ-035 rst_n pulsed low after 3 of 4 captures -> outputs at reset values; no frame_valid until 4 new captures, then bcd reflects only post-reset digits.
